simon_seq_engine: RTL and testbench

Parametrised Simon sequencer core: stores a colour sequence, plays back a growing prefix on one-hot lamps, accepts player presses over a valid/ready handshake, and grades them level by level until win, mistake or timeout. Generalises the fixed 4-colour, fixed-length game FSM to N colours, configurable sequence depth, timed lamp display and an input timeout. Sits between the board I/O (switches, keys, LEDs) and the HEX display logic, which reads `state` and `level`.

---
 rtl/simon_pkg.sv | 18 +
 rtl/simon_lfsr.sv | 21 ++
 rtl/simon_seq_engine.sv | 200 ++++++++++++++++++++
 tb/tb_simon_seq_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared state codes and colour decode for the Simon sequencer.
package simon_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SHOW     = 4'd1,
        ST_GAP      = 4'd2,
        ST_INPUT    = 4'd3,
        ST_LEVEL_UP = 4'd4,
        ST_WIN      = 4'd5,
        ST_LOSE     = 4'd6
    } simon_state_e;

    function automatic logic [15:0] color_onehot(input logic [3:0] c);
        color_onehot = 16'd1 << c;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,15,13,4) used as the colour source when SIMON_LFSR_EN is defined.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] q
);

    localparam logic [15:0] SEED = 16'hACE1;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else if (step) begin
            q <= {q[14:0], q[15] ^ q[14] ^ q[12] ^ q[3]};
        end
    end

endmodule

// File: rtl/simon_seq_engine.sv
// Simon sequencer core: timed playback of a growing prefix, graded player input.
// Optional macro SIMON_LFSR_EN: random sequence generation from an internal LFSR.
//
// state    | meaning
// IDLE     | waiting for start; write port active
// SHOW     | lamp lit with mem[idx] for SHOW_CYCLES
// GAP      | lamp dark for GAP_CYCLES, then next colour or INPUT
// INPUT    | grading presses against mem[idx], optional timeout
// LEVEL_UP | one cycle: extend the prefix and replay
// WIN/LOSE | one-cycle result pulse, back to IDLE
module simon_seq_engine #(
    parameter int COLORS      = 4,
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int TIMEOUT     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_LEN)-1:0]   wr_addr,
    input  logic [$clog2(COLORS)-1:0]    wr_data,
    input  logic                         btn_valid,
    input  logic [$clog2(COLORS)-1:0]    btn_color,
    output logic                         in_ready,
    output logic [COLORS-1:0]            lamp,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic [3:0]                   state,
    output logic                         win,
    output logic                         lose,
    output logic                         busy
);
    import simon_pkg::*;

    localparam int CW    = $clog2(COLORS);
    localparam int AW    = $clog2(MAX_LEN);
    localparam int LW    = $clog2(MAX_LEN+1);
    localparam int CMAX  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNTW  = $clog2(CMAX+1);
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
    localparam int TLOAD = (TIMEOUT > 0) ? TIMEOUT-1 : 0;

    localparam logic [3:0] S_IDLE     = ST_IDLE;
    localparam logic [3:0] S_SHOW     = ST_SHOW;
    localparam logic [3:0] S_GAP      = ST_GAP;
    localparam logic [3:0] S_INPUT    = ST_INPUT;
    localparam logic [3:0] S_LEVEL_UP = ST_LEVEL_UP;
    localparam logic [3:0] S_WIN      = ST_WIN;
    localparam logic [3:0] S_LOSE     = ST_LOSE;

    logic [CW-1:0]     mem [MAX_LEN];
    logic [3:0]        state_q;
    logic [LW-1:0]     level_q;
    logic [AW-1:0]     idx_q;
    logic [CNTW-1:0]   cnt_q;
    logic [TW-1:0]     tmr_q;
    logic [COLORS-1:0] lamp_q;
    logic              win_q;
    logic              lose_q;

    logic              accept;
    logic [LW-1:0]     idx_inc;
    logic [CW-1:0]     first_color;
    logic [CW-1:0]     next_color;

    function automatic logic [COLORS-1:0] oh(input logic [CW-1:0] c);
        logic [15:0] w;
        w  = color_onehot(4'(c));
        oh = w[COLORS-1:0];
    endfunction

    assign accept     = btn_valid && (state_q == S_INPUT);
    assign idx_inc    = LW'(idx_q) + LW'(1);
    assign next_color = mem[AW'(idx_inc)];

`ifdef SIMON_LFSR_EN
    logic [15:0] lfsr_q;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (1'b1),
        .q     (lfsr_q)
    );

    assign first_color = lfsr_q[CW-1:0];
`else
    // A same-cycle write to entry 0 must be what the first lamp shows.
    assign first_color = (wr_en && (wr_addr == '0)) ? wr_data : mem[0];
`endif

    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_IDLE) && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
`ifdef SIMON_LFSR_EN
        if (!reset && (state_q == S_IDLE) && start) begin
            mem[0] <= lfsr_q[CW-1:0];
        end
        if (!reset && (state_q == S_LEVEL_UP)) begin
            mem[AW'(level_q)] <= lfsr_q[CW-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            lamp_q  <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            win_q  <= 1'b0;
            lose_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SHOW;
                        level_q <= LW'(1);
                        idx_q   <= '0;
                        cnt_q   <= CNTW'(SHOW_CYCLES-1);
                        lamp_q  <= oh(first_color);
                    end
                end
                S_SHOW: begin
                    if (cnt_q == '0) begin
                        state_q <= S_GAP;
                        cnt_q   <= CNTW'(GAP_CYCLES-1);
                        lamp_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (idx_inc == level_q) begin
                        state_q <= S_INPUT;
                        idx_q   <= '0;
                        tmr_q   <= TW'(TLOAD);
                    end else begin
                        state_q <= S_SHOW;
                        idx_q   <= idx_q + 1'b1;
                        cnt_q   <= CNTW'(SHOW_CYCLES-1);
                        lamp_q  <= oh(next_color);
                    end
                end
                S_INPUT: begin
                    if (accept) begin
                        tmr_q <= TW'(TLOAD);
                        if (btn_color != mem[idx_q]) begin
                            state_q <= S_LOSE;
                            lose_q  <= 1'b1;
                        end else if (idx_inc == level_q) begin
                            if (level_q == LW'(MAX_LEN)) begin
                                state_q <= S_WIN;
                                win_q   <= 1'b1;
                            end else begin
                                state_q <= S_LEVEL_UP;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (TIMEOUT > 0) begin
                        if (tmr_q == '0) begin
                            state_q <= S_LOSE;
                            lose_q  <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q - 1'b1;
                        end
                    end
                end
                S_LEVEL_UP: begin
                    state_q <= S_SHOW;
                    level_q <= level_q + 1'b1;
                    idx_q   <= '0;
                    cnt_q   <= CNTW'(SHOW_CYCLES-1);
                    lamp_q  <= oh(mem[0]);
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state_q == S_INPUT);
    assign busy     = (state_q != S_IDLE);
    assign lamp     = lamp_q;
    assign level    = level_q;
    assign state    = state_q;
    assign win      = win_q;
    assign lose     = lose_q;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed bench for simon_seq_engine: one DUT without timeout, one with TIMEOUT=8.
module tb_simon_seq_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_color = '0;

    logic       in_ready, win, lose, busy;
    logic [3:0] lamp, state;
    logic [2:0] level;
    logic       in_ready_t, win_t, lose_t, busy_t;
    logic [3:0] lamp_t, state_t;
    logic [2:0] level_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simon_seq_engine #(.COLORS(4), .MAX_LEN(4), .SHOW_CYCLES(2), .GAP_CYCLES(1), .TIMEOUT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .btn_valid(btn_valid), .btn_color(btn_color),
        .in_ready(in_ready), .lamp(lamp), .level(level), .state(state),
        .win(win), .lose(lose), .busy(busy)
    );

    simon_seq_engine #(.COLORS(4), .MAX_LEN(4), .SHOW_CYCLES(2), .GAP_CYCLES(1), .TIMEOUT(8)) dut_t (
        .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .btn_valid(btn_valid), .btn_color(btn_color),
        .in_ready(in_ready_t), .lamp(lamp_t), .level(level_t), .state(state_t),
        .win(win_t), .lose(lose_t), .busy(busy_t)
    );

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_mem(input logic [1:0] a, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1; btn_color = c;
        tick();
        btn_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_input(input bit use_t, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((use_t ? in_ready_t : in_ready) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: in_ready never rose within 200 cycles", name);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({state, lamp, level, in_ready, win, lose, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d lamp=%b level=%0d rdy=%b win=%b lose=%b busy=%b, want all 0",
                     state, lamp, level, in_ready, win, lose, busy);
        end
    endtask

    task automatic test_playback();
        write_mem(2'd0, 2'd2);
        write_mem(2'd1, 2'd0);
        write_mem(2'd2, 2'd3);
        write_mem(2'd3, 2'd1);
        do_start();
        checks++;
        if (lamp !== 4'b0100 || state !== 4'd1 || level !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL play_c1: lamp=%b state=%0d level=%0d busy=%b, want 0100 1 1 1", lamp, state, level, busy);
        end
        tick();
        checks++;
        if (lamp !== 4'b0100 || state !== 4'd1) begin
            errors++;
            $display("FAIL play_c2: lamp=%b state=%0d, want 0100 1", lamp, state);
        end
        tick();
        checks++;
        if (lamp !== 4'b0000 || state !== 4'd2) begin
            errors++;
            $display("FAIL play_c3: lamp=%b state=%0d, want 0000 2", lamp, state);
        end
        tick();
        checks++;
        if (state !== 4'd3 || in_ready !== 1'b1 || lamp !== 4'b0000) begin
            errors++;
            $display("FAIL play_c4: state=%0d rdy=%b lamp=%b, want 3 1 0000", state, in_ready, lamp);
        end
    endtask

    task automatic test_level_up();
        press(2'd2);
        checks++;
        if (state !== 4'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lvlup_state: state=%0d rdy=%b, want 4 0", state, in_ready);
        end
        tick();
        checks++;
        if (state !== 4'd1 || level !== 3'd2 || lamp !== 4'b0100) begin
            errors++;
            $display("FAIL lvl2_show0: state=%0d level=%0d lamp=%b, want 1 2 0100", state, level, lamp);
        end
        tick();
        tick();
        checks++;
        if (state !== 4'd2 || lamp !== 4'b0000) begin
            errors++;
            $display("FAIL lvl2_gap0: state=%0d lamp=%b, want 2 0000", state, lamp);
        end
        tick();
        checks++;
        if (state !== 4'd1 || lamp !== 4'b0001) begin
            errors++;
            $display("FAIL lvl2_show1: state=%0d lamp=%b, want 1 0001", state, lamp);
        end
        tick();
        tick();
        checks++;
        if (state !== 4'd2 || lamp !== 4'b0000) begin
            errors++;
            $display("FAIL lvl2_gap1: state=%0d lamp=%b, want 2 0000", state, lamp);
        end
        tick();
        checks++;
        if (state !== 4'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lvl2_input: state=%0d rdy=%b, want 3 1", state, in_ready);
        end
    endtask

    task automatic test_win();
        press(2'd2);
        checks++;
        if (state !== 4'd3 || level !== 3'd2) begin
            errors++;
            $display("FAIL mid_press: state=%0d level=%0d, want 3 2", state, level);
        end
        press(2'd0);
        wait_input(1'b0, "win_l3");
        press(2'd2); press(2'd0); press(2'd3);
        wait_input(1'b0, "win_l4");
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL win_level4: level=%0d, want 4", level);
        end
        press(2'd2); press(2'd0); press(2'd3); press(2'd1);
        checks++;
        if (win !== 1'b1 || lose !== 1'b0 || state !== 4'd5) begin
            errors++;
            $display("FAIL win_pulse: win=%b lose=%b state=%0d, want 1 0 5", win, lose, state);
        end
        tick();
        checks++;
        if (win !== 1'b0 || state !== 4'd0 || level !== 3'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL win_after: win=%b state=%0d level=%0d busy=%b, want 0 0 4 0", win, state, level, busy);
        end
    endtask

    task automatic test_lose();
        do_start();
        wait_input(1'b0, "lose_l1");
        press(2'd2);
        btn_valid = 1'b1; btn_color = 2'd3;
        tick();
        tick();
        btn_valid = 1'b0;
        checks++;
        if (state !== 4'd1 || lose !== 1'b0 || level !== 3'd2) begin
            errors++;
            $display("FAIL btn_in_show: state=%0d lose=%b level=%0d, want 1 0 2", state, lose, level);
        end
        wait_input(1'b0, "lose_l2");
        press(2'd2);
        press(2'd3);
        checks++;
        if (lose !== 1'b1 || win !== 1'b0 || state !== 4'd6) begin
            errors++;
            $display("FAIL lose_pulse: lose=%b win=%b state=%0d, want 1 0 6", lose, win, state);
        end
        tick();
        checks++;
        if (lose !== 1'b0 || state !== 4'd0 || level !== 3'd2) begin
            errors++;
            $display("FAIL lose_after: lose=%b state=%0d level=%0d, want 0 0 2", lose, state, level);
        end
    endtask

    task automatic test_timeout();
        bit early;
        do_reset();
        do_start();
        wait_input(1'b1, "to_entry");
        early = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (lose_t !== 1'b0 || state_t !== 4'd3) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL timeout_early: lost before 8 idle cycles (state=%0d), want state 3", state_t);
        end
        tick();
        checks++;
        if (lose_t !== 1'b1 || state_t !== 4'd6 || state !== 4'd3) begin
            errors++;
            $display("FAIL timeout_fire: lose_t=%b state_t=%0d state=%0d, want 1 6 3", lose_t, state_t, state);
        end

        do_reset();
        do_start();
        wait_input(1'b1, "to_l1");
        press(2'd2);
        wait_input(1'b1, "to_l2");
        for (int k = 1; k <= 7; k++) tick();
        press(2'd2);
        checks++;
        if (state_t !== 4'd3 || lose_t !== 1'b0) begin
            errors++;
            $display("FAIL timeout_c7_press: state_t=%0d lose_t=%b, want 3 0", state_t, lose_t);
        end
        early = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (lose_t !== 1'b0 || state_t !== 4'd3) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL timeout_restart_early: lost before restarted count expired (state=%0d)", state_t);
        end
        tick();
        checks++;
        if (lose_t !== 1'b1 || state_t !== 4'd6) begin
            errors++;
            $display("FAIL timeout_restart_fire: lose_t=%b state_t=%0d, want 1 6", lose_t, state_t);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 2'd1;
        tick();
        wr_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (state !== 4'd0 || lamp !== 4'b0000 || level !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: state=%0d lamp=%b level=%0d busy=%b, want 0 0000 0 0", state, lamp, level, busy);
        end
        do_start();
        checks++;
        if (lamp !== 4'b0100) begin
            errors++;
            $display("FAIL wr_in_show: lamp=%b, want 0100 (mem[0] unchanged)", lamp);
        end
    endtask

    task automatic test_start_write();
        do_reset();
        start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 2'd3;
        tick();
        start = 1'b0; wr_en = 1'b0;
        checks++;
        if (lamp !== 4'b1000 || state !== 4'd1) begin
            errors++;
            $display("FAIL start_with_write: lamp=%b state=%0d, want 1000 1", lamp, state);
        end
    endtask

`ifdef SIMON_LFSR_EN
    task automatic test_lfsr_repeat();
        logic [3:0] first;
        do_reset();
        tick(); tick(); tick();
        do_start();
        first = lamp;
        checks++;
        if (!$onehot(first)) begin
            errors++;
            $display("FAIL lfsr_onehot: lamp=%b, want one-hot", first);
        end
        do_reset();
        tick(); tick(); tick();
        do_start();
        checks++;
        if (lamp !== first) begin
            errors++;
            $display("FAIL lfsr_repeat: lamp=%b, want %b", lamp, first);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SIMON_LFSR_EN
        test_lfsr_repeat();
`else
        test_playback();
        test_level_up();
        test_win();
        test_lose();
        test_timeout();
        test_reset_mid();
        test_start_write();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
